// File: rtl/dm_responder.sv
// Data-memory responder for the core's MEM stage: zero-latency loads, byte-lane stores,
// sticky first-fault capture. Define DM_ACCESS_CNT_EN to build the load/store counters.
module dm_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int          INIT_ZERO  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_w,
  input  logic                  mem_r,
  input  logic [31:0]           addr,
  input  logic [31:0]           din,
  input  logic [2:0]            dm_type,
  output logic [31:0]           dout,
  output logic                  fault,
  output logic [31:0]           fault_addr,
  input  logic [ADDR_WIDTH-1:0] dbg_sel,
  output logic [31:0]           dbg_data,
  output logic [31:0]           load_cnt,
  output logic [31:0]           store_cnt
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

  typedef enum logic [2:0] {
    DM_W  = 3'b000,
    DM_HS = 3'b001,
    DM_HU = 3'b010,
    DM_BS = 3'b011,
    DM_BU = 3'b100
  } dm_type_e;

  // Time-zero contents only; reset never touches the array.
  logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           word_rd;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic                  legal;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           rdata;

  assign idx      = addr[ADDR_WIDTH+1:2];
  assign word_rd  = mem[idx];
  assign lane_b   = word_rd[{addr[1:0], 3'b000} +: 8];
  assign lane_h   = word_rd[{addr[1], 4'b0000} +: 16];
  assign dbg_data = mem[dbg_sel];

  always_comb begin
    legal = 1'b0;
    be    = '0;
    wdata = '0;
    rdata = '0;
    case (dm_type)
      DM_W: begin
        legal = (addr[1:0] == 2'b00);
        be    = 4'b1111;
        wdata = din;
        rdata = word_rd;
      end
      DM_HS, DM_HU: begin
        legal = ~addr[0];
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{din[15:0]}};
        rdata = {{16{(dm_type == DM_HS) & lane_h[15]}}, lane_h};
      end
      DM_BS, DM_BU: begin
        legal = 1'b1;
        be    = 4'b0001 << addr[1:0];
        wdata = {4{din[7:0]}};
        rdata = {{24{(dm_type == DM_BS) & lane_b[7]}}, lane_b};
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Reads the pre-edge array, so a same-cycle store is only visible next cycle.
  assign dout = (mem_r && legal) ? rdata : '0;

  always_ff @(posedge clk) begin
    if (!reset && mem_w && legal) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if ((mem_r || mem_w) && !legal && !fault) begin
      fault      <= 1'b1;
      fault_addr <= addr;
    end
  end

`ifdef DM_ACCESS_CNT_EN
  logic [31:0] load_cnt_q;
  logic [31:0] store_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      if (mem_r && legal) load_cnt_q  <= load_cnt_q + 32'd1;
      if (mem_w && legal) store_cnt_q <= store_cnt_q + 32'd1;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
`else
  assign load_cnt  = '0;
  assign store_cnt = '0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed vector table, reset/counter sequences,
// then random traffic against a byte-addressed reference model.
module tb_dm_responder;

  localparam int unsigned AW     = 10;
  localparam int unsigned NBYTES = 4 << AW;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          mem_w   = 1'b0;
  logic          mem_r   = 1'b0;
  logic [31:0]   addr    = '0;
  logic [31:0]   din     = '0;
  logic [2:0]    dm_type = '0;
  logic [AW-1:0] dbg_sel = '0;
  logic [31:0]   dout;
  logic          fault;
  logic [31:0]   fault_addr;
  logic [31:0]   dbg_data;
  logic [31:0]   load_cnt;
  logic [31:0]   store_cnt;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  ref_b [NBYTES];
  logic        ref_fault;
  logic [31:0] ref_fa;
  logic [31:0] ref_lc;
  logic [31:0] ref_sc;

  typedef struct {
    bit          w;
    bit          r;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_dout;
    logic [31:0] exp_dbg;
    bit          exp_fault;
    logic [31:0] exp_fa;
  } vec_t;

  vec_t tbl [20];

  dm_responder #(.ADDR_WIDTH(AW), .INIT_ZERO(1)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .mem_r(mem_r), .addr(addr), .din(din),
    .dm_type(dm_type), .dout(dout), .fault(fault), .fault_addr(fault_addr),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] t);
    case (t)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic bit acc_legal(input logic [31:0] a, input logic [2:0] t);
    int unsigned n;
    n = acc_size(t);
    return (n != 0) && ((a % n) == 0);
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  function automatic logic [31:0] ref_load(input bit r, input logic [31:0] a, input logic [2:0] t);
    int unsigned n;
    int unsigned base;
    longint      v;
    if (!r || !acc_legal(a, t)) return '0;
    n    = acc_size(t);
    base = a % NBYTES;
    v    = 0;
    for (int unsigned k = 0; k < n; k++) v += longint'(ref_b[base+k]) << (8*k);
    if ((t == 3'd1 || t == 3'd3) && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  task automatic drive(input bit rst, input bit w, input bit r, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d);
    reset   = rst;
    mem_w   = w;
    mem_r   = r;
    dm_type = t;
    addr    = a;
    din     = d;
  endtask

  // Advance one clock edge and apply the same edge to the reference model.
  task automatic tick();
    bit          ok;
    int unsigned base;
    @(posedge clk);
    ok = acc_legal(addr, dm_type);
    if (reset) begin
      ref_fault = 1'b0;
      ref_fa    = '0;
      ref_lc    = '0;
      ref_sc    = '0;
    end else begin
      if ((mem_r || mem_w) && !ok && !ref_fault) begin
        ref_fault = 1'b1;
        ref_fa    = addr;
      end
      if (mem_r && ok) ref_lc = ref_lc + 32'd1;
      if (mem_w && ok) begin
        ref_sc = ref_sc + 32'd1;
        base   = addr % NBYTES;
        for (int unsigned k = 0; k < acc_size(dm_type); k++) ref_b[base+k] = din[8*k +: 8];
      end
    end
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, " fault"}, 32'(fault), 32'(ref_fault));
    check({tag, " fault_addr"}, fault_addr, ref_fa);
`ifdef DM_ACCESS_CNT_EN
    check({tag, " load_cnt"}, load_cnt, ref_lc);
    check({tag, " store_cnt"}, store_cnt, ref_sc);
`else
    check({tag, " load_cnt"}, load_cnt, 32'h0);
    check({tag, " store_cnt"}, store_cnt, 32'h0);
`endif
  endtask

  initial begin
    logic [31:0] ra;

    tbl = '{
      '{1, 0, 3'd0, 32'h10,   32'hDEADBEEF, 32'h0,        32'h0,        0, 32'h0},
      '{0, 1, 3'd0, 32'h10,   32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h0},
      '{0, 1, 3'd3, 32'h13,   32'h0,        32'hFFFFFFDE, 32'hDEADBEEF, 0, 32'h0},
      '{0, 1, 3'd4, 32'h13,   32'h0,        32'h000000DE, 32'hDEADBEEF, 0, 32'h0},
      '{1, 0, 3'd3, 32'h21,   32'h123456AB, 32'h0,        32'hDEADBEEF, 0, 32'h0},
      '{0, 1, 3'd0, 32'h20,   32'h0,        32'h0000AB00, 32'hDEADBEEF, 0, 32'h0},
      '{1, 0, 3'd1, 32'h22,   32'h0000CAFE, 32'h0,        32'hDEADBEEF, 0, 32'h0},
      '{0, 1, 3'd0, 32'h20,   32'h0,        32'hCAFEAB00, 32'hDEADBEEF, 0, 32'h0},
      '{0, 1, 3'd1, 32'h22,   32'h0,        32'hFFFFCAFE, 32'hDEADBEEF, 0, 32'h0},
      '{0, 1, 3'd2, 32'h22,   32'h0,        32'h0000CAFE, 32'hDEADBEEF, 0, 32'h0},
      '{0, 1, 3'd0, 32'h30,   32'h0,        32'h0,        32'hDEADBEEF, 0, 32'h0},
      '{1, 0, 3'd0, 32'h31,   32'h11111111, 32'h0,        32'hDEADBEEF, 1, 32'h31},
      '{0, 1, 3'd0, 32'h30,   32'h0,        32'h0,        32'hDEADBEEF, 1, 32'h31},
      '{0, 1, 3'd1, 32'h45,   32'h0,        32'h0,        32'hDEADBEEF, 1, 32'h31},
      '{0, 1, 3'd6, 32'h10,   32'h0,        32'h0,        32'hDEADBEEF, 1, 32'h31},
      '{1, 0, 3'd0, 32'h1004, 32'hA5A5A5A5, 32'h0,        32'hDEADBEEF, 1, 32'h31},
      '{0, 1, 3'd0, 32'h4,    32'h0,        32'hA5A5A5A5, 32'hDEADBEEF, 1, 32'h31},
      '{1, 0, 3'd0, 32'h8,    32'h1,        32'h0,        32'hDEADBEEF, 1, 32'h31},
      '{1, 1, 3'd0, 32'h8,    32'h2,        32'h1,        32'hDEADBEEF, 1, 32'h31},
      '{0, 1, 3'd0, 32'h8,    32'h0,        32'h2,        32'hDEADBEEF, 1, 32'h31}
    };

    for (int unsigned i = 0; i < NBYTES; i++) ref_b[i] = 8'h00;
    ref_fault = 1'b0;
    ref_fa    = '0;
    ref_lc    = '0;
    ref_sc    = '0;

    // Reset state
    drive(1, 0, 0, 3'd0, 32'h0, 32'h0);
    dbg_sel = AW'(5);
    tick();
    tick();
    check("reset dout", dout, 32'h0);
    check("reset fault", 32'(fault), 32'h0);
    check("reset fault_addr", fault_addr, 32'h0);
    check("reset load_cnt", load_cnt, 32'h0);
    check("reset store_cnt", store_cnt, 32'h0);
    check("init dbg_data", dbg_data, 32'h0);

    // Directed vectors: combinational outputs before the edge, fault state after it
    dbg_sel = AW'(4);
    for (int i = 0; i < 20; i++) begin
      drive(0, tbl[i].w, tbl[i].r, tbl[i].t, tbl[i].a, tbl[i].d);
      #1;
      check($sformatf("vec%0d dout", i), dout, tbl[i].exp_dout);
      check($sformatf("vec%0d dbg_data", i), dbg_data, tbl[i].exp_dbg);
      tick();
      check($sformatf("vec%0d fault", i), 32'(fault), 32'(tbl[i].exp_fault));
      check($sformatf("vec%0d fault_addr", i), fault_addr, tbl[i].exp_fa);
    end

    // Reset clears fault state, suppresses a concurrent store and keeps the array
    drive(1, 1, 0, 3'd0, 32'h10, 32'h0);
    tick();
    check("rst fault", 32'(fault), 32'h0);
    check("rst fault_addr", fault_addr, 32'h0);
    drive(0, 0, 1, 3'd0, 32'h20, 32'h0);
    #1;
    check("rst kept dbg", dbg_data, 32'hDEADBEEF);
    check("rst kept dout", dout, 32'hCAFEAB00);
    tick();

`ifdef DM_ACCESS_CNT_EN
    drive(1, 0, 0, 3'd0, 32'h0, 32'h0);
    tick();
    drive(0, 0, 1, 3'd0, 32'h10, 32'h0);         tick();
    drive(0, 0, 1, 3'd4, 32'h13, 32'h0);         tick();
    drive(0, 0, 1, 3'd2, 32'h22, 32'h0);         tick();
    drive(0, 1, 0, 3'd0, 32'h40, 32'h1);         tick();
    drive(0, 1, 0, 3'd3, 32'h41, 32'h22);        tick();
    drive(0, 1, 0, 3'd0, 32'h42, 32'h3);         tick();
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0);
    check("cnt loads", load_cnt, 32'd3);
    check("cnt stores", store_cnt, 32'd2);
    @(negedge clk);
    force dut.store_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.store_cnt_q;
    ref_sc = 32'hFFFF_FFFF;
    drive(0, 1, 0, 3'd0, 32'h40, 32'h7);
    tick();
    check("cnt store wrap", store_cnt, 32'h0);
`else
    check("cnt off loads", load_cnt, 32'h0);
    check("cnt off stores", store_cnt, 32'h0);
`endif

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra & 32'h0000_00FF;
      drive($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), ra, $urandom);
      dbg_sel = ($urandom_range(0, 1) == 0) ? ra[AW+1:2] : AW'($urandom);
      #1;
      check("rnd dout", dout, ref_load(mem_r, addr, dm_type));
      check("rnd dbg_data", dbg_data, ref_word(dbg_sel));
      tick();
      check_regs("rnd");
    end

    drive(0, 0, 0, 3'd0, 32'h0, 32'h0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
